// File: rtl/ppu_out_packer.sv
// Packs the PPU's uint8 output stream little-endian into 32-bit words and issues
// addressed, byte-strobed write requests to the global buffer through a small FIFO.
module ppu_out_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  num_bytes,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [31:0]          out_data,
  output logic [3:0]           out_wstrb,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           strb;
  } entry_t;

  state_t               r_state;
  logic [1:0]           r_lane;
  logic [CNT_BITS-1:0]  r_left;
  logic [ADDR_BITS-1:0] r_addr;
  logic [31:0]          r_pack;
  logic                 r_done;

  entry_t               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_start_ok;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_push;
  logic                 w_pop;
  logic [31:0]          w_word;
  logic [3:0]           w_strb;
  entry_t               w_entry;
  entry_t               w_head;

  // The DRAIN cycle with an empty FIFO is the done cycle, which also takes a new start.
  assign w_start_ok = start && ((r_state == S_IDLE) || ((r_state == S_DRAIN) && (r_count == '0)));
  assign in_ready   = (r_state == S_RUN) && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_left == CNT_BITS'(1));
  assign w_push     = w_accept && ((r_lane == 2'd3) || w_last);
  assign w_pop      = (r_count != '0) && out_ready;

  // Merge the incoming byte into the pack register; lanes above it stay zero.
  always_comb begin
    w_word = r_pack;
    w_strb = 4'b0000;
    case (r_lane)
      2'd0: begin w_word[7:0]   = in_data; w_strb = 4'b0001; end
      2'd1: begin w_word[15:8]  = in_data; w_strb = 4'b0011; end
      2'd2: begin w_word[23:16] = in_data; w_strb = 4'b0111; end
      default: begin w_word[31:24] = in_data; w_strb = 4'b1111; end
    endcase
  end

  always_comb begin
    w_entry      = '0;
    w_entry.addr = r_addr;
    w_entry.data = w_word;
    w_entry.strb = w_strb;
  end

  // Tile control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lane  <= 2'd0;
      r_left  <= '0;
      r_addr  <= '0;
      r_pack  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DRAIN: begin
          if (w_start_ok) begin
            if (num_bytes == '0) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RUN;
              r_lane  <= 2'd0;
              r_left  <= num_bytes;
              r_addr  <= base_addr & ~ADDR_BITS'(3);
              r_pack  <= '0;
            end
          end else if (r_state == S_DRAIN) begin
            if (r_count == '0) begin
              r_state <= S_IDLE;
            end else if (w_pop && (r_count == CNT_W'(1))) begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            r_left <= r_left - CNT_BITS'(1);
            r_pack <= w_push ? 32'd0 : w_word;
            if (w_push) begin
              r_addr <= r_addr + ADDR_BITS'(4);
            end
            if (w_push && w_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Word FIFO; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign out_addr  = w_head.addr;
  assign out_data  = w_head.data;
  assign out_wstrb = w_head.strb;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_ppu_out_packer.sv
// Directed bench for ppu_out_packer: a queue-based model of the expected write stream
// checked every cycle, plus literal expectations for selected words and timings.
module tb_ppu_out_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_bytes = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_wstrb;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  ppu_out_packer #(.FIFO_DEPTH(4), .ADDR_BITS(32), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_wstrb(out_wstrb),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        obs_q[$];
  logic [7:0] tb_bytes [64];
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, last_pop_cyc = 0, last_done_cyc = 0, done_cnt = 0, acc_cnt = 0;
  bit zero_mode = 1'b0;
  int n0, d0;
  wr_t w;
  logic prev_stall = 1'b0;
  wr_t  prev_head;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected writes for a tile: little-endian words, strobes for filled lanes.
  task automatic model_tile(input logic [31:0] base, input int n);
    for (int wi = 0; wi * 4 < n; wi++) begin
      wr_t e;
      e.addr = (base & 32'hFFFF_FFFC) + 32'(4 * wi);
      e.data = '0;
      e.strb = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * wi + l < n) begin
          e.data = e.data | (32'(tb_bytes[4 * wi + l]) << (8 * l));
          e.strb[l] = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (start) start_cyc = cyc;
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_addr", 64'(out_addr), 64'(prev_head.addr));
        chk("stall_data", 64'(out_data), 64'(prev_head.data));
        chk("stall_strb", 64'(out_wstrb), 64'(prev_head.strb));
      end
      if (out_valid && out_ready) begin
        wr_t o;
        o.addr = out_addr; o.data = out_data; o.strb = out_wstrb;
        obs_q.push_back(o);
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required none", out_addr, out_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(out_addr), 64'(e.addr));
          chk("wr_data", 64'(out_data), 64'(e.data));
          chk("wr_strb", 64'(out_wstrb), 64'(e.strb));
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (zero_mode) begin
          chk("done_zero_latency", 64'(cyc - start_cyc), 64'(1));
        end else begin
          chk("done_latency", 64'(cyc - last_pop_cyc), 64'(1));
          chk("done_model_empty", 64'(exp_q.size()), 64'(0));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_head.addr = out_addr; prev_head.data = out_data; prev_head.strb = out_wstrb;
    end
  end

  task automatic pulse_start(input logic [31:0] b, input int n);
    @(posedge clk); #1;
    base_addr = b; num_bytes = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input int n);
    int idx = 0;
    int guard = 0;
    logic acc;
    while (idx < n && guard < 2000) begin
      in_valid = 1'b1;
      in_data  = tb_bytes[idx];
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; acc_cnt++; end
      guard++;
    end
    in_valid = 1'b0;
    if (idx < n) begin
      checks++; errors++;
      $display("FAIL send_bytes: sent %0d required %0d", idx, n);
    end
  endtask

  task automatic wait_done(input int prev, input string name);
    int t = 0;
    while (done_cnt == prev && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(done_cnt), 64'(prev + 1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_wstrb", 64'(out_wstrb), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Full words, no backpressure
    for (int i = 0; i < 8; i++) tb_bytes[i] = 8'(i + 1);
    model_tile(32'h100, 8);
    n0 = obs_q.size(); d0 = done_cnt;
    pulse_start(32'h100, 8);
    chk("t1_busy_after_start", 64'(busy), 64'(1));
    chk("t1_in_ready_after_start", 64'(in_ready), 64'(1));
    send_bytes(8);
    wait_done(d0, "t1_done");
    chk("t1_nwrites", 64'(obs_q.size() - n0), 64'(2));
    w = obs_q[n0];
    chk("t1_w0_addr", 64'(w.addr), 64'h100);
    chk("t1_w0_data", 64'(w.data), 64'h0403_0201);
    chk("t1_w0_strb", 64'(w.strb), 64'hF);
    w = obs_q[n0 + 1];
    chk("t1_w1_addr", 64'(w.addr), 64'h104);
    chk("t1_w1_data", 64'(w.data), 64'h0807_0605);
    chk("t1_done_cycle", 64'(last_done_cyc - start_cyc), 64'(10));
    @(posedge clk); #1;
    chk("t1_busy_low", 64'(busy), 64'(0));

    // Partial final word
    for (int i = 0; i < 6; i++) tb_bytes[i] = 8'(8'hAA + i);
    model_tile(32'h40, 6);
    n0 = obs_q.size(); d0 = done_cnt;
    pulse_start(32'h40, 6);
    send_bytes(6);
    wait_done(d0, "t2_done");
    repeat (5) @(posedge clk);
    chk("t2_single_done", 64'(done_cnt), 64'(d0 + 1));
    chk("t2_nwrites", 64'(obs_q.size() - n0), 64'(2));
    w = obs_q[n0 + 1];
    chk("t2_w1_addr", 64'(w.addr), 64'h44);
    chk("t2_w1_data", 64'(w.data), 64'h0000_AFAE);
    chk("t2_w1_strb", 64'(w.strb), 64'h3);

    // Zero-length tile
    n0 = obs_q.size(); d0 = done_cnt;
    zero_mode = 1'b1;
    pulse_start(32'h80, 0);
    chk("t3_busy_stays_low", 64'(busy), 64'(0));
    wait_done(d0, "t3_done");
    zero_mode = 1'b0;
    repeat (4) @(posedge clk);
    chk("t3_no_writes", 64'(obs_q.size() - n0), 64'(0));

    // Backpressure fill, then release while full
    for (int i = 0; i < 32; i++) tb_bytes[i] = 8'(i * 7 + 3);
    model_tile(32'h1000, 32);
    n0 = obs_q.size(); d0 = done_cnt;
    out_ready = 1'b0; acc_cnt = 0;
    pulse_start(32'h1000, 32);
    fork
      send_bytes(32);
      begin
        repeat (24) @(negedge clk);
        chk("t4_accepted_when_full", 64'(acc_cnt), 64'(16));
        chk("t4_in_ready_full", 64'(in_ready), 64'(0));
        chk("t4_out_valid_full", 64'(out_valid), 64'(1));
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_release_cycle", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("t4_in_ready_after_pop", 64'(in_ready), 64'(1));
      end
    join
    wait_done(d0, "t4_done");
    chk("t4_nwrites", 64'(obs_q.size() - n0), 64'(8));

    // Start issued mid-tile is ignored
    for (int i = 0; i < 12; i++) tb_bytes[i] = 8'(8'h30 + i);
    model_tile(32'h300, 12);
    n0 = obs_q.size(); d0 = done_cnt;
    pulse_start(32'h300, 12);
    fork
      send_bytes(12);
      begin
        repeat (5) @(posedge clk);
        #1 base_addr = 32'h900; num_bytes = 16'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    wait_done(d0, "t5_done");
    chk("t5_nwrites", 64'(obs_q.size() - n0), 64'(3));
    w = obs_q[obs_q.size() - 1];
    chk("t5_last_addr", 64'(w.addr), 64'h308);
    chk("t5_last_data", 64'(w.data), 64'h3B3A_3938);

    // Reset mid-tile
    for (int i = 0; i < 12; i++) tb_bytes[i] = 8'(8'h50 + i);
    out_ready = 1'b0;
    d0 = done_cnt;
    pulse_start(32'h500, 12);
    send_bytes(5);
    chk("t6_word_pending", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    chk("t6_no_done", 64'(done_cnt), 64'(d0));
    tb_bytes[0] = 8'h11; tb_bytes[1] = 8'h22; tb_bytes[2] = 8'h33; tb_bytes[3] = 8'h44;
    model_tile(32'h200, 4);
    n0 = obs_q.size(); d0 = done_cnt;
    pulse_start(32'h200, 4);
    send_bytes(4);
    wait_done(d0, "t6_new_done");
    chk("t6_nwrites", 64'(obs_q.size() - n0), 64'(1));
    w = obs_q[obs_q.size() - 1];
    chk("t6_addr", 64'(w.addr), 64'h200);
    chk("t6_data", 64'(w.data), 64'h4433_2211);
    chk("t6_strb", 64'(w.strb), 64'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_out_packer.md
# ppu_out_packer

Downstream neighbour of the post-processing unit (PPU): collects the PPU's stream of saturated uint8 activations, packs them little-endian into 32-bit words, and presents addressed, byte-strobed write requests to the global-buffer write port through a small FIFO. One `start` programs a tile (base address and byte count). `done` is pulsed once every word of that tile has been accepted downstream.

## Interface
- `FIFO_DEPTH`, default 4: entries in the word FIFO; power of two, minimum 2.
- `ADDR_BITS`, default 32: width of the byte address.
- `CNT_BITS`, default 16: width of the tile byte count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high; all state is cleared immediately on assertion.
- `start` in 1: one-cycle pulse; latches `base_addr` and `num_bytes`; ignored unless the block is idle.
- `base_addr` in ADDR_BITS: byte address of the first output; must be 4-byte aligned (bits [1:0] are ignored and treated as 0).
- `num_bytes` in CNT_BITS: number of uint8 outputs in the tile.
- `in_valid` in 1: PPU output byte valid.
- `in_data` in 8: PPU `data_out` byte.
- `in_ready` out 1: packer accepts a byte this cycle.
- `out_valid` out 1: write request valid (FIFO head).
- `out_addr` out ADDR_BITS: word address, `base_addr + 4*word_index`.
- `out_data` out 32: packed word; the first byte of the word is in [7:0].
- `out_wstrb` out 4: byte enables; bit i covers `out_data[8i+7:8i]`.
- `out_ready` in 1: downstream accepts the request.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at tile completion.

## Operation
- FSM states are IDLE, RUN, and DRAIN.
- IDLE + `start`, `num_bytes`≠0: latch the tile parameters, clear the lane index, set `bytes_left = num_bytes`, and go to RUN.
- IDLE + `start`, `num_bytes`=0: pulse `done` in the next cycle and stay in IDLE. No words are emitted.
- RUN:
  - `in_ready = (count < FIFO_DEPTH)`. It is computed from registered state only; there is no combinational path from `out_ready`.
  - Each accepted byte is written into lane `lane_idx` of the pack register. Then `lane_idx` increments mod 4 and `bytes_left` decrements.
  - A word is pushed to the FIFO in the same cycle that lane 3 is filled or the last byte (`bytes_left`==1) is accepted.
  - The pushed word carries `wstrb` = lanes filled (4'b1111, or 4'b0001/0011/0111 for a partial final word). Unfilled lanes of `out_data` are 0.
  - The address is `base + 4*word_idx`; `word_idx` increments per push.
  - After the push of the last byte, go to DRAIN.
- DRAIN: `in_ready`=0. When the FIFO is empty, pulse `done`, drop `busy`, and go to IDLE.
- FIFO:
  - Push and pop may occur in the same cycle; `count` is then unchanged, including when the FIFO is full.
  - The head is stable while `out_valid && !out_ready`.
- A `start` while `busy` has no effect.
- `in_valid` in IDLE or DRAIN is not accepted, because `in_ready` is 0.
- Reset mid-tile discards the partial word and all FIFO contents; no `done` is generated.

## Timing
- Reset values of outputs:
  - `in_ready`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_wstrb`=0, `busy`=0, `done`=0.
  - The FSM is in IDLE.
- `start` accepted at edge T gives `busy`=1 and `in_ready`=1 from T+1.
- The 4th byte of a word is accepted at edge T; `out_valid` is high from T+1, so minimum latency is 1 cycle.
- With `out_ready` held high and `in_valid` held high, throughput is 1 byte/cycle. The FIFO never fills; a word leaves every 4 cycles.
- The last word is popped at edge T: `done`=1 during T+1 and `busy`=0 from T+2.
- Back-to-back tiles: `start` is accepted in the cycle `done` is high.
- Wrap-around:
  - `word_idx` and FIFO pointers wrap naturally.
  - The address adder is ADDR_BITS wide; overflow wraps mod 2^ADDR_BITS.

## Test plan
- **Full words, no backpressure.** Stimulus: `start` with base=0x100, num_bytes=8; bytes 0x01..0x08 with `out_ready`=1. Required response: two writes, (0x100, 0x04030201, 1111) and (0x104, 0x08070605, 1111); `done` 1 cycle after the second pop.
- **Partial final word.** Stimulus: num_bytes=6, bytes 0xAA..0xAF. Required response: second write is (base+4, 0x0000AFAE, 0011); exactly one `done`.
- **Backpressure fill.** Stimulus: `out_ready`=0, num_bytes=32, continuous `in_valid`. Required response: `in_ready` falls after 16 bytes (4 words); with `out_ready` released, all 8 words arrive in order with stable data while stalled; no byte is lost.
- **Simultaneous push/pop at full.** Stimulus: FIFO full, then `out_ready`=1 on the same cycle the lane-3 byte would arrive. Required response: `in_ready` is 0 that cycle (registered count) and the byte is taken next cycle; the word sequence is intact.
- **Zero-length and ignored start.** Stimulus: `start` with num_bytes=0; then a `start` issued mid-tile. Required response: the zero-length start gives `done` at T+1 with no writes; the mid-tile `start` leaves the tile parameters unchanged.
- **Reset mid-tile.** Stimulus: assert `rst` after 5 of 12 bytes. Required response: immediate `out_valid`=0, `busy`=0, and no `done`; a new tile afterwards starts at lane 0 / word 0.
